// File: rtl/decode_onehot_seq.sv
// ---------------------------------------------------------------------------
// decode_onehot_seq
//
// Purpose:
//   Decodes a register code into a registered one-hot enable vector. Three
//   behaviours are selectable:
//     direct : Y follows onehot(W) one cycle after En is sampled high
//     pulse  : a latched code is held on Y for STRETCH cycles
//     sweep  : codes 0..N-1 are walked in order, STRETCH cycles each. En low
//              pauses the walk without losing its place.
//   A one-cycle completion state (FIN) follows every pulse and every sweep.
//
// Parameters:
//   SEL_W   - width of the register-code field
//   STRETCH - cycles each code stays asserted in pulse/sweep modes (1..15)
//   N       - derived one-hot width, 2**SEL_W
//
// Ports:
//   Clock  - single clock, rising-edge active
//   Resetn - asynchronous, active-low reset
//   W      - register code
//   En     - decoder enable (pauses sweep, ignored during pulse)
//   Mode   - 00 direct, 01 pulse, 10 sweep, 11 direct
//   Start  - level-sampled start request for pulse/sweep
//   Y      - registered one-hot output; Y[k] is asserted for code k, and
//            bit 0 is the leftmost bit
//   Busy   - high while a pulse or sweep is in progress (including pauses)
//   Done   - one-cycle completion strobe
//   Code   - code currently driven on Y (0 when Y is zero)
// ---------------------------------------------------------------------------
module decode_onehot_seq #(
  parameter  int SEL_W   = 3,
  parameter  int STRETCH = 1,
  localparam int N       = 2 ** SEL_W
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [SEL_W-1:0] W,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic             Start,
  output logic [0:N-1]     Y,
  output logic             Busy,
  output logic             Done,
  output logic [SEL_W-1:0] Code
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    SWEEP = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [3:0]       STRETCH_M1 = 4'(STRETCH - 1);
  localparam logic [SEL_W-1:0] LAST_CODE  = SEL_W'(N - 1);

  state_t             state, state_next;
  logic [0:N-1]       y_next;
  logic               busy_next;
  logic               done_next;
  logic [SEL_W-1:0]   code_next;

  // Sweep bookkeeping. sweep_code/cnt describe the next slot to be shown,
  // not the one currently on Y; sweep_last marks that the final slot of
  // code N-1 has already been shown.
  logic [SEL_W-1:0]   sweep_code, sweep_code_next;
  logic [3:0]         cnt, cnt_next;
  logic               sweep_last, sweep_last_next;

  // Result of consuming one display slot from (src_code, src_cnt).
  logic [SEL_W-1:0]   src_code;
  logic [3:0]         src_cnt;
  logic [SEL_W-1:0]   adv_code;
  logic [3:0]         adv_cnt;
  logic               adv_last;

  function automatic logic [0:N-1] onehot(input logic [SEL_W-1:0] c);
    logic [0:N-1] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  // Slot advance shared by the sweep launch (starting from code 0 with a
  // full stretch) and every shown sweep cycle. The code counter saturates
  // at N-1 and raises adv_last instead of wrapping.
  always_comb begin
    if (state == IDLE) begin
      src_code = '0;
      src_cnt  = STRETCH_M1;
    end else begin
      src_code = sweep_code;
      src_cnt  = cnt;
    end

    adv_code = src_code;
    adv_cnt  = src_cnt;
    adv_last = 1'b0;
    if (src_cnt == 4'd0) begin
      if (src_code == LAST_CODE) begin
        adv_last = 1'b1;
      end else begin
        adv_code = src_code + SEL_W'(1);
        adv_cnt  = STRETCH_M1;
      end
    end else begin
      adv_cnt = src_cnt - 4'd1;
    end
  end

  // Next-state and next-output logic. Every output is registered, so the
  // values computed here appear on the ports one cycle later. Defaults
  // describe an idle, zero-output cycle.
  always_comb begin
    state_next      = state;
    y_next          = '0;
    busy_next       = 1'b0;
    done_next       = 1'b0;
    code_next       = '0;
    sweep_code_next = sweep_code;
    cnt_next        = cnt;
    sweep_last_next = sweep_last;

    unique case (state)
      IDLE: begin
        sweep_code_next = '0;
        cnt_next        = '0;
        sweep_last_next = 1'b0;
        unique case (Mode)
          2'b01: begin
            if (Start && En) begin
              state_next = PULSE;
              y_next     = onehot(W);
              code_next  = W;
              busy_next  = 1'b1;
              cnt_next   = STRETCH_M1;
            end
          end
          2'b10: begin
            // The launch cycle already shows code 0, so the counters
            // advance past that first slot right away.
            if (Start && En) begin
              state_next      = SWEEP;
              y_next          = onehot('0);
              code_next       = '0;
              busy_next       = 1'b1;
              sweep_code_next = adv_code;
              cnt_next        = adv_cnt;
              sweep_last_next = adv_last;
            end
          end
          default: begin
            if (En) begin
              y_next    = onehot(W);
              code_next = W;
            end
          end
        endcase
      end

      PULSE: begin
        // En, W, Mode and Start are deliberately not looked at: a pulse
        // always runs to completion with the code latched at launch.
        if (cnt == 4'd0) begin
          state_next = FIN;
          done_next  = 1'b1;
        end else begin
          cnt_next  = cnt - 4'd1;
          y_next    = Y;
          code_next = Code;
          busy_next = 1'b1;
        end
      end

      SWEEP: begin
        if (sweep_last) begin
          state_next = FIN;
          done_next  = 1'b1;
        end else begin
          busy_next = 1'b1;
          // En low produces a pause cycle: Y stays zero and the counters
          // hold, so the walk resumes exactly where it stopped.
          if (En) begin
            y_next          = onehot(sweep_code);
            code_next       = sweep_code;
            sweep_code_next = adv_code;
            cnt_next        = adv_cnt;
            sweep_last_next = adv_last;
          end
        end
      end

      FIN: begin
        // Start is not sampled here; a held Start is picked up by the
        // following IDLE cycle instead.
        state_next      = IDLE;
        sweep_code_next = '0;
        cnt_next        = '0;
        sweep_last_next = 1'b0;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears everything immediately, which
  // also aborts any pulse or sweep in flight without raising Done.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= IDLE;
      Y          <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Code       <= '0;
      sweep_code <= '0;
      cnt        <= '0;
      sweep_last <= 1'b0;
    end else begin
      state      <= state_next;
      Y          <= y_next;
      Busy       <= busy_next;
      Done       <= done_next;
      Code       <= code_next;
      sweep_code <= sweep_code_next;
      cnt        <= cnt_next;
      sweep_last <= sweep_last_next;
    end
  end

endmodule

// File: tb/tb_decode_onehot_seq.sv
// ---------------------------------------------------------------------------
// tb_decode_onehot_seq
//
// Purpose:
//   Self-checking bench for decode_onehot_seq. Three instances share one
//   stimulus stream:
//     dut_a : SEL_W=3, STRETCH=3 (direct and pulse behaviour)
//     dut_b : SEL_W=3, STRETCH=1 (sweep, pause and async reset)
//     dut_c : SEL_W=4, STRETCH=1 (wide decode and 16-code sweep)
//   Inputs change on the falling edge; outputs are sampled 1 ns after the
//   rising edge.
// ---------------------------------------------------------------------------
module tb_decode_onehot_seq;

  logic        clock;
  logic        resetn;
  logic [3:0]  w4;
  logic        en;
  logic [1:0]  mode;
  logic        start;

  logic [0:7]  y_a, y_b;
  logic [0:15] y_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic [2:0]  code_a, code_b;
  logic [3:0]  code_c;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] w;
    logic       en;
    logic [1:0] mode;
    logic       start;
    logic [7:0] y;
    logic [2:0] code;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[12];

  decode_onehot_seq #(.SEL_W(3), .STRETCH(3)) dut_a (
    .Clock(clock), .Resetn(resetn), .W(w4[2:0]), .En(en), .Mode(mode),
    .Start(start), .Y(y_a), .Busy(busy_a), .Done(done_a), .Code(code_a)
  );

  decode_onehot_seq #(.SEL_W(3), .STRETCH(1)) dut_b (
    .Clock(clock), .Resetn(resetn), .W(w4[2:0]), .En(en), .Mode(mode),
    .Start(start), .Y(y_b), .Busy(busy_b), .Done(done_b), .Code(code_b)
  );

  decode_onehot_seq #(.SEL_W(4), .STRETCH(1)) dut_c (
    .Clock(clock), .Resetn(resetn), .W(w4), .En(en), .Mode(mode),
    .Start(start), .Y(y_c), .Busy(busy_c), .Done(done_c), .Code(code_c)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  // Drive one set of inputs for one clock, then leave time just past the
  // rising edge so the registered outputs can be sampled.
  task automatic applyStimulus(input logic [3:0] w_v, input logic en_v,
                               input logic [1:0] mode_v, input logic start_v);
    @(negedge clock);
    w4    = w_v;
    en    = en_v;
    mode  = mode_v;
    start = start_v;
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    @(negedge clock);
    resetn = 1'b0;
    w4     = '0;
    en     = 1'b0;
    mode   = 2'b00;
    start  = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    logic [7:0]  exp8;
    logic [15:0] exp16;
    int          busy_count;
    int          done_count;
    logic        en_v;

    resetn = 1'b0;
    w4     = '0;
    en     = 1'b0;
    mode   = 2'b00;
    start  = 1'b0;

    // Direct and pulse table for dut_a (STRETCH=3), one row per clock.
    vecs[0]  = '{w: 3'd5, en: 1'b1, mode: 2'b00, start: 1'b0, y: 8'b00000100, code: 3'd5, busy: 1'b0, done: 1'b0};
    vecs[1]  = '{w: 3'd5, en: 1'b0, mode: 2'b00, start: 1'b0, y: 8'b00000000, code: 3'd0, busy: 1'b0, done: 1'b0};
    vecs[2]  = '{w: 3'd0, en: 1'b1, mode: 2'b11, start: 1'b0, y: 8'b10000000, code: 3'd0, busy: 1'b0, done: 1'b0};
    vecs[3]  = '{w: 3'd7, en: 1'b1, mode: 2'b11, start: 1'b1, y: 8'b00000001, code: 3'd7, busy: 1'b0, done: 1'b0};
    vecs[4]  = '{w: 3'd2, en: 1'b0, mode: 2'b01, start: 1'b1, y: 8'b00000000, code: 3'd0, busy: 1'b0, done: 1'b0};
    vecs[5]  = '{w: 3'd2, en: 1'b1, mode: 2'b01, start: 1'b1, y: 8'b00100000, code: 3'd2, busy: 1'b1, done: 1'b0};
    vecs[6]  = '{w: 3'd6, en: 1'b0, mode: 2'b00, start: 1'b0, y: 8'b00100000, code: 3'd2, busy: 1'b1, done: 1'b0};
    vecs[7]  = '{w: 3'd1, en: 1'b1, mode: 2'b10, start: 1'b1, y: 8'b00100000, code: 3'd2, busy: 1'b1, done: 1'b0};
    vecs[8]  = '{w: 3'd1, en: 1'b1, mode: 2'b00, start: 1'b1, y: 8'b00000000, code: 3'd0, busy: 1'b0, done: 1'b1};
    vecs[9]  = '{w: 3'd3, en: 1'b1, mode: 2'b00, start: 1'b0, y: 8'b00000000, code: 3'd0, busy: 1'b0, done: 1'b0};
    vecs[10] = '{w: 3'd3, en: 1'b1, mode: 2'b00, start: 1'b0, y: 8'b00010000, code: 3'd3, busy: 1'b0, done: 1'b0};
    vecs[11] = '{w: 3'd4, en: 1'b1, mode: 2'b01, start: 1'b0, y: 8'b00000000, code: 3'd0, busy: 1'b0, done: 1'b0};

    // Reset state, observed before any clock edge.
    #3;
    checkOutput("reset_y_a", 32'(y_a), 32'h0);
    checkOutput("reset_busy_a", 32'(busy_a), 32'h0);
    checkOutput("reset_done_a", 32'(done_a), 32'h0);
    checkOutput("reset_code_a", 32'(code_a), 32'h0);
    checkOutput("reset_y_c", 32'(y_c), 32'h0);

    doReset();
    for (int i = 0; i < 12; i++) begin
      applyStimulus({1'b0, vecs[i].w}, vecs[i].en, vecs[i].mode, vecs[i].start);
      checkOutput($sformatf("vec%0d_y", i), 32'(y_a), 32'(vecs[i].y));
      checkOutput($sformatf("vec%0d_code", i), 32'(code_a), 32'(vecs[i].code));
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy_a), 32'(vecs[i].busy));
      checkOutput($sformatf("vec%0d_done", i), 32'(done_a), 32'(vecs[i].done));
    end

    // Start held through FIN is only picked up by the following IDLE cycle.
    doReset();
    applyStimulus(4'd4, 1'b1, 2'b01, 1'b1);
    applyStimulus(4'd4, 1'b1, 2'b01, 1'b1);
    applyStimulus(4'd4, 1'b1, 2'b01, 1'b1);
    applyStimulus(4'd4, 1'b1, 2'b01, 1'b1);
    checkOutput("held_fin_done", 32'(done_a), 32'h1);
    applyStimulus(4'd4, 1'b1, 2'b01, 1'b1);
    checkOutput("held_idle_busy", 32'(busy_a), 32'h0);
    checkOutput("held_idle_y", 32'(y_a), 32'h0);
    applyStimulus(4'd4, 1'b1, 2'b01, 1'b1);
    checkOutput("held_restart_busy", 32'(busy_a), 32'h1);
    checkOutput("held_restart_y", 32'(y_a), 32'h08);

    // Full sweeps: dut_b walks 8 codes, dut_c walks 16.
    doReset();
    applyStimulus(4'd0, 1'b1, 2'b10, 1'b1);
    checkOutput("sweep_b_y0", 32'(y_b), 32'h80);
    checkOutput("sweep_b_busy0", 32'(busy_b), 32'h1);
    checkOutput("sweep_c_y0", 32'(y_c), 32'h8000);
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(4'd0, 1'b1, 2'b10, 1'b0);
      if (k < 8) begin
        exp8 = 8'h80 >> k;
        checkOutput($sformatf("sweep_b_y%0d", k), 32'(y_b), 32'(exp8));
        checkOutput($sformatf("sweep_b_code%0d", k), 32'(code_b), k);
        checkOutput($sformatf("sweep_b_busy%0d", k), 32'(busy_b), 32'h1);
      end else if (k == 8) begin
        checkOutput("sweep_b_done", 32'(done_b), 32'h1);
        checkOutput("sweep_b_fin_y", 32'(y_b), 32'h0);
        checkOutput("sweep_b_fin_busy", 32'(busy_b), 32'h0);
      end
      if (k < 16) begin
        exp16 = 16'h8000 >> k;
        checkOutput($sformatf("sweep_c_y%0d", k), 32'(y_c), 32'(exp16));
        checkOutput($sformatf("sweep_c_code%0d", k), 32'(code_c), k);
      end else begin
        checkOutput("sweep_c_done", 32'(done_c), 32'h1);
      end
    end

    // Sweep pause: En low for the two edges where code 3 would appear.
    doReset();
    busy_count = 0;
    done_count = 0;
    applyStimulus(4'd0, 1'b1, 2'b10, 1'b1);
    if (busy_b) busy_count++;
    for (int i = 1; i <= 12; i++) begin
      en_v = !(i == 3 || i == 4);
      applyStimulus(4'd0, en_v, 2'b10, 1'b0);
      if (busy_b) busy_count++;
      if (done_b) done_count++;
      if (i == 3) begin
        checkOutput("pause_y", 32'(y_b), 32'h0);
        checkOutput("pause_busy", 32'(busy_b), 32'h1);
      end
      if (i == 5) begin
        checkOutput("resume_code", 32'(code_b), 32'h3);
        checkOutput("resume_y", 32'(y_b), 32'h10);
      end
      if (i == 10) checkOutput("pause_done", 32'(done_b), 32'h1);
    end
    checkOutput("pause_busy_total", busy_count, 32'd10);
    checkOutput("pause_done_total", done_count, 32'd1);

    // Async reset between edges while the sweep shows code 4.
    doReset();
    applyStimulus(4'd0, 1'b1, 2'b10, 1'b1);
    for (int i = 1; i <= 4; i++) applyStimulus(4'd0, 1'b1, 2'b10, 1'b0);
    checkOutput("prereset_code", 32'(code_b), 32'h4);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("areset_y", 32'(y_b), 32'h0);
    checkOutput("areset_busy", 32'(busy_b), 32'h0);
    checkOutput("areset_done", 32'(done_b), 32'h0);
    checkOutput("areset_code", 32'(code_b), 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    w4     = 4'd6;
    en     = 1'b1;
    mode   = 2'b00;
    start  = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("postreset_direct_y", 32'(y_b), 32'h02);
    done_count = 0;
    if (done_b) done_count++;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'd0, 1'b0, 2'b00, 1'b0);
      if (done_b) done_count++;
    end
    checkOutput("postreset_no_done", done_count, 32'd0);

    // Wide decode on the SEL_W=4 instance.
    applyStimulus(4'd15, 1'b1, 2'b00, 1'b0);
    checkOutput("wide_y15", 32'(y_c), 32'h0001);
    checkOutput("wide_code15", 32'(code_c), 32'hF);
    checkOutput("narrow_y7", 32'(y_a), 32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_onehot_seq.md
DECODE_ONEHOT_SEQ -- requirements
Module: decode_onehot_seq

Interface
REQ-001 The block SHALL have parameter SEL_W, default 3, meaning the width of the register-code field.
REQ-002 The block SHALL have parameter STRETCH, default 1, meaning cycles each code stays asserted in pulse and sweep modes (legal 1..15).
REQ-003 The block SHALL have derived constant N = 2**SEL_W, meaning the one-hot output width.
REQ-004 Clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Resetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 W  input  SEL_W  SHALL be the register code (XXX/YYY field).
REQ-007 En  input  1  SHALL be the decoder enable.
REQ-008 Mode  input  2  SHALL select behaviour: 00 direct, 01 pulse, 10 sweep, 11 treated as direct.
REQ-009 Start  input  1  SHALL be the level-sampled start request for pulse/sweep modes.
REQ-010 Y  output  [0:N-1]  SHALL be the registered one-hot enable; Y[k] is asserted for code k, so code 0 drives bit 0 (leftmost).
REQ-011 Busy  output  1  SHALL be high while a pulse or sweep is in progress.
REQ-012 Done  output  1  SHALL be a one-cycle completion strobe.
REQ-013 Code  output  SEL_W  SHALL be the code currently driven on Y (0 when Y is zero).

Function
REQ-014 Y SHALL always be all-zero or exactly one-hot; never multi-hot.
REQ-015 States SHALL be IDLE, PULSE, SWEEP, FIN.
REQ-016 IDLE with Mode 00/11: Y SHALL equal onehot(W) one cycle after En=1 is sampled, else zero; Busy=0, Done=0; Start ignored.
REQ-017 IDLE with Mode 01, Start=1 and En=1 sampled: block SHALL latch W and mode, go to PULSE, and drive onehot(latched W) on Y from the next cycle for exactly STRETCH cycles.
REQ-018 IDLE with Mode 10, Start=1 and En=1 sampled: block SHALL go to SWEEP and drive codes 0,1,...,N-1 in order, each for STRETCH cycles.
REQ-019 Start with En=0 in IDLE SHALL be ignored (no state change, Y=0).
REQ-020 Busy SHALL be high in every cycle Y carries a PULSE/SWEEP code and during SWEEP pauses.
REQ-021 During SWEEP, En=0 SHALL pause: Y=0, code and stretch counters hold, Busy stays 1; resuming with En=1 continues at the held code and remaining stretch count.
REQ-022 En is ignored during PULSE (pulse always completes).
REQ-023 After the last stretch cycle of PULSE or code N-1 of SWEEP, block SHALL enter FIN for one cycle: Y=0, Busy=0, Done=1, then IDLE.
REQ-024 Start, W and Mode changes while Busy or in FIN SHALL be ignored; a Start held high through FIN SHALL be re-sampled in IDLE the following cycle.
REQ-025 Sweep code counter SHALL be SEL_W bits; reaching N-1 terminates the sweep and never wraps to 0 within a sweep.
REQ-026 Stretch counter SHALL be 4 bits, counting down from STRETCH-1.

Reset
REQ-027 Resetn=0 SHALL immediately, without a clock edge, force state IDLE, Y=0, Busy=0, Done=0, Code=0, counters 0.
REQ-028 Reset asserted mid-PULSE or mid-SWEEP SHALL abort without Done; after release the block SHALL respond to direct decode on the first rising edge.

Verification
REQ-029 Direct: SEL_W=3, Mode=00, En=1, W=101 -> next cycle Y=00000100, Code=5; En=0 -> next cycle Y=00000000.
REQ-030 Pulse: STRETCH=3, Mode=01, W=010, Start=1 one cycle -> Y=00100000 and Busy=1 for 3 cycles, then Done=1 one cycle with Y=0, W changes during pulse have no effect.
REQ-031 Sweep: STRETCH=1, Mode=10, Start -> Y walks 10000000 ... 00000001 over 8 cycles, Code 0..7, then Done.
REQ-032 Sweep pause: drop En for 2 cycles while Code=3 -> Y=0, Busy=1 for 2 cycles, resume at Code=3; total Busy = 10 cycles.
REQ-033 Async reset: assert Resetn=0 between edges during sweep at Code=4 -> Y, Busy, Done, Code zero immediately; no Done after release.
REQ-034 Parameter: SEL_W=4 direct decode of W=1111 -> Y[15]=1 only; sweep runs 16 codes.
